// File: rtl/twilight_fade_sequencer.sv
// twilight_fade_sequencer: frame-strobe driven RISE/HOLD_HI/FALL/HOLD_LO fade
// generator with prescaled saturating ramps and phase/step/cycle status.
// Optional feature macro: TWILIGHT_PAUSE_EN adds a pause input that freezes
// the sequencer while asserted.
module twilight_fade_sequencer #(
  parameter int unsigned STEP            = 1,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned HOLD_HI_FRAMES  = 120,
  parameter int unsigned HOLD_LO_FRAMES  = 120
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       frame,
`ifdef TWILIGHT_PAUSE_EN
  input  logic       pause,
`endif
  output logic [7:0] fade_level,
  output logic       direction,
  output logic [1:0] phase,
  output logic       step_pulse,
  output logic       cycle_done
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LVL_W = 8;

  typedef enum logic [1:0] {
    PH_RISE    = 2'd0,
    PH_HOLD_HI = 2'd1,
    PH_FALL    = 2'd2,
    PH_HOLD_LO = 2'd3
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               step_q, step_d;
  logic               done_q, done_d;

  logic               adv_c;
  logic [LVL_W:0]     sum_c;
  logic signed [9:0]  diff_c;

  // A frame only advances the sequencer when not frozen.
`ifdef TWILIGHT_PAUSE_EN
  assign adv_c = frame & ~pause;
`else
  assign adv_c = frame;
`endif

  // Ramp arithmetic: widened so saturation can be detected before truncation.
  assign sum_c  = {1'b0, level_q} + (LVL_W+1)'(STEP);
  assign diff_c = $signed({2'b00, level_q}) - $signed(10'(STEP));

  // Next-state and output decode.
  always_comb begin
    phase_d = phase_q;
    level_d = level_q;
    dir_d   = dir_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    if (adv_c) begin
      unique case (phase_q)
        PH_RISE: begin
          if (presc_q == CNT_W'(FRAMES_PER_STEP - 1)) begin
            presc_d = '0;
            step_d  = 1'b1;
            if (sum_c >= (LVL_W+1)'(255)) begin
              level_d = 8'd255;
              phase_d = PH_HOLD_HI;
              hold_d  = '0;
            end else begin
              level_d = sum_c[LVL_W-1:0];
            end
          end else begin
            presc_d = presc_q + CNT_W'(1);
          end
        end
        PH_HOLD_HI: begin
          if (hold_q == CNT_W'(HOLD_HI_FRAMES - 1)) begin
            phase_d = PH_FALL;
            dir_d   = 1'b0;
            presc_d = '0;
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
        PH_FALL: begin
          if (presc_q == CNT_W'(FRAMES_PER_STEP - 1)) begin
            presc_d = '0;
            step_d  = 1'b1;
            if (diff_c <= 10'sd0) begin
              level_d = '0;
              phase_d = PH_HOLD_LO;
              hold_d  = '0;
            end else begin
              level_d = diff_c[LVL_W-1:0];
            end
          end else begin
            presc_d = presc_q + CNT_W'(1);
          end
        end
        PH_HOLD_LO: begin
          if (hold_q == CNT_W'(HOLD_LO_FRAMES - 1)) begin
            phase_d = PH_RISE;
            dir_d   = 1'b1;
            presc_d = '0;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
        default: phase_d = PH_RISE;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over frame/pause.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      phase_q <= PH_RISE;
      level_q <= '0;
      dir_q   <= 1'b1;
      presc_q <= '0;
      hold_q  <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign fade_level = level_q;
  assign direction  = dir_q;
  assign phase      = phase_q;
  assign step_pulse = step_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_twilight_fade_sequencer.sv
// Self-checking bench for twilight_fade_sequencer: directed scenarios plus
// random frame/reset traffic against a frame-counting reference model.
module tb_twilight_fade_sequencer;

  localparam int STEP = 64;
  localparam int FPS  = 2;
  localparam int HH   = 3;
  localparam int HL   = 2;

  logic       clk_pix = 1'b0;
  logic       rst     = 1'b0;
  logic       frame   = 1'b0;
  logic       pause   = 1'b0;
  logic [7:0] fade_level;
  logic       direction;
  logic [1:0] phase;
  logic       step_pulse;
  logic       cycle_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: frames counted since the last ramp step / hold entry.
  int m_level, m_phase, m_dir, m_cnt, m_step, m_done;
  int pulses;

  twilight_fade_sequencer #(
    .STEP(STEP), .FRAMES_PER_STEP(FPS), .HOLD_HI_FRAMES(HH), .HOLD_LO_FRAMES(HL)
  ) dut (
    .clk_pix   (clk_pix),
    .rst       (rst),
    .frame     (frame),
`ifdef TWILIGHT_PAUSE_EN
    .pause     (pause),
`endif
    .fade_level(fade_level),
    .direction (direction),
    .phase     (phase),
    .step_pulse(step_pulse),
    .cycle_done(cycle_done)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_phase = 0; m_dir = 1; m_cnt = 0; m_step = 0; m_done = 0;
  endtask

  task automatic model_frame();
    m_step = 0; m_done = 0;
    m_cnt++;
    case (m_phase)
      0: if (m_cnt == FPS) begin
           m_cnt = 0; m_step = 1; m_level = m_level + STEP;
           if (m_level >= 255) begin m_level = 255; m_phase = 1; end
         end
      1: if (m_cnt == HH) begin m_cnt = 0; m_phase = 2; m_dir = 0; end
      2: if (m_cnt == FPS) begin
           m_cnt = 0; m_step = 1; m_level = m_level - STEP;
           if (m_level <= 0) begin m_level = 0; m_phase = 3; end
         end
      default: if (m_cnt == HL) begin m_cnt = 0; m_phase = 0; m_dir = 1; m_done = 1; end
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"}, 32'(fade_level), 32'(m_level));
    chk({tag, ".phase"}, 32'(phase),      32'(m_phase));
    chk({tag, ".dir"},   32'(direction),  32'(m_dir));
    chk({tag, ".step"},  32'(step_pulse), 32'(m_step));
    chk({tag, ".done"},  32'(cycle_done), 32'(m_done));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic tick(input logic f, input logic r, input string tag);
    frame = f;
    rst   = r;
    @(posedge clk_pix);
    #1;
    if (r) model_reset();
    else if (f && !pause) model_frame();
    else begin m_step = 0; m_done = 0; end
    if (step_pulse === 1'b1) pulses++;
    check_model(tag);
  endtask

  // Frame strobe followed by an idle cycle.
  task automatic frames(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0, tag);
      tick(1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    model_reset();
    pulses = 0;

    // Reset, with frame asserted in the same cycle as rst.
    tick(1'b0, 1'b1, "rst0");
    tick(1'b1, 1'b1, "rst1");
    chk("rst.level", 32'(fade_level), 32'd0);
    chk("rst.dir",   32'(direction),  32'd1);
    chk("rst.phase", 32'(phase),      32'd0);

    // Rise: 8 frames to saturation.
    pulses = 0;
    frames(8, "rise");
    chk("rise.level_end", 32'(fade_level), 32'd255);
    chk("rise.phase_end", 32'(phase),      32'd1);
    chk("rise.pulses",    32'(pulses),     32'd4);

    // Hold high then fall.
    frames(3, "hold_hi");
    chk("hold_hi.phase_end", 32'(phase),     32'd2);
    chk("hold_hi.dir_end",   32'(direction), 32'd0);
    frames(8, "fall");
    chk("fall.level_end", 32'(fade_level), 32'd0);
    chk("fall.phase_end", 32'(phase),      32'd3);

    // Hold low then back to rise with a single-cycle cycle_done.
    tick(1'b1, 1'b0, "hold_lo");
    tick(1'b0, 1'b0, "hold_lo");
    tick(1'b1, 1'b0, "hold_lo");
    chk("wrap.done", 32'(cycle_done), 32'd1);
    chk("wrap.phase", 32'(phase),     32'd0);
    tick(1'b0, 1'b0, "wrap_idle");
    chk("wrap.done_clr", 32'(cycle_done), 32'd0);
    chk("wrap.level",    32'(fade_level), 32'd0);

    // Back-to-back frames from reset.
    tick(1'b0, 1'b1, "rst2");
    pulses = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, "b2b");
    chk("b2b.level",  32'(fade_level), 32'd128);
    chk("b2b.pulses", 32'(pulses),     32'd2);

    // Reset during FALL at level 191.
    tick(1'b0, 1'b1, "rst3");
    frames(8 + 3 + 2, "to191");
    chk("to191.level", 32'(fade_level), 32'd191);
    tick(1'b1, 1'b1, "rst_fall");
    chk("rst_fall.level", 32'(fade_level), 32'd0);
    chk("rst_fall.phase", 32'(phase),      32'd0);
    chk("rst_fall.dir",   32'(direction),  32'd1);
    chk("rst_fall.step",  32'(step_pulse), 32'd0);

`ifdef TWILIGHT_PAUSE_EN
    // Pause freezes everything; release resumes with prescaler at 1.
    tick(1'b0, 1'b1, "rst4");
    frames(3, "pre_pause");
    chk("pause.level_pre", 32'(fade_level), 32'd64);
    pause = 1'b1;
    frames(10, "paused");
    chk("pause.level_hold", 32'(fade_level), 32'd64);
    pause = 1'b0;
    tick(1'b1, 1'b0, "resume");
    chk("pause.level_post", 32'(fade_level), 32'd128);
`endif

    // Random frame/reset traffic.
    tick(1'b0, 1'b1, "rst5");
    for (int i = 0; i < 600; i++) begin
      tick(1'(($urandom % 3) != 0), 1'(($urandom % 150) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
